pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer, the next generation of the 4-bit PC. Generalised address width. Adds synchronous jump, conditional branch, a call/return stack of configurable depth, and stall (enable). Sits between instruction decode and program ROM address; its `pc` output drives the ROM address directly.

Parameters:
- ADDR_W, 4, width of PC, jump target and stack entries.
- STACK_DEPTH, 4, number of return-address entries; must be ≥1.
- RESET_ADDR, 0, PC value loaded on reset; truncated to ADDR_W.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, advance enable; 0 = stall, hold all state.
- jump, input, 1, unconditional load of target.
- branch, input, 1, conditional load of target when cond=1.
- cond, input, 1, branch condition (flag from ALU).
- call, input, 1, push return address (pc+1), load target.
- ret, input, 1, pop stack into pc.
- target, input, ADDR_W, jump/branch/call destination.
- pc, output, ADDR_W, current program address (registered).
- stack_empty, output, 1, stack holds 0 entries.
- stack_full, output, 1, stack holds STACK_DEPTH entries.
- stack_err, output, 1, sticky: overflow or underflow attempted.

Behaviour:
- Reset, synchronous, highest priority:
  - pc = RESET_ADDR.
  - Stack pointer = 0.
  - stack_empty = 1, stack_full = 0, stack_err = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-call or mid-return discards the pending operation.
- Stall: en=0 holds pc, stack pointer, stack contents and stack_err. All control inputs are ignored.
- Priority when en=1, one action per cycle: call > ret > jump > (branch & cond) > increment.
- call:
  - If not full: stack[sp] = pc+1 (mod 2^ADDR_W), sp++, pc = target.
  - If full: no push, pc = pc+1, stack_err set.
- ret:
  - If not empty: sp--, pc = stack[sp-1].
  - If empty: pc = pc+1, stack_err set.
- jump: pc = target.
- branch with cond=1: pc = target. With cond=0: pc = pc+1.
- Increment: pc = pc+1, wrapping from 2^ADDR_W-1 to 0. Wrap is not an error.
- Single-cycle latency: the control input sampled at edge N is reflected on pc after edge N.
- stack_empty and stack_full are combinational from the registered sp; they update in the same cycle sp changes.
- stack_err is cleared only by rst.
- Return address pushed by a call at pc = 2^ADDR_W-1 wraps to 0.
- Simultaneous call+ret: call wins, ret is ignored (no pop).
- Stack is LIFO; sp width is clog2(STACK_DEPTH+1).

Optional Feature:
- Macro: PCSEQ_SKIP_EN.
- When defined:
  - Adds input `skip` (1 bit).
  - With en=1 and no higher-priority action, skip=1 sets pc = pc+2 (mod 2^ADDR_W), for skip-next-instruction opcodes.
  - Priority: below branch-taken, above plain increment.
  - A not-taken branch with skip=1 gives pc+2.
- When undefined: no `skip` port, and the increment step is always +1.

Test Plan (ADDR_W=4, STACK_DEPTH=2, RESET_ADDR=0 unless stated):
- Reset and increment: rst=1 for 1 cycle, then 17 cycles of en=1 with no controls -> pc runs 0,1,…,15,0 (wrap); stack_empty=1, stack_err=0.
- Jump, branch and stall:
  - At pc=3: jump=1, target=9 -> pc=9.
  - Then branch=1, cond=0 -> pc=10.
  - Then branch=1, cond=1, target=2 -> pc=2.
  - Then en=0 for 3 cycles with jump=1 -> pc stays 2.
- Nested call/return:
  - At pc=5: call target=12 -> pc=12, stack_empty=0.
  - At pc=12: call target=7 -> pc=7, stack_full=1.
  - ret -> pc=13.
  - ret -> pc=6, stack_empty=1, stack_err=0.
- Overflow and underflow:
  - With stack full at pc=4, call target=0 -> pc=5, stack_err=1, sp unchanged.
  - After reset, ret at pc=0 -> pc=1, stack_err=1.
  - stack_err stays 1 until rst.
- Simultaneous events and reset mid-call:
  - call=1, ret=1, jump=1, target=8 at pc=2 -> pc=8, one entry (3) pushed.
  - Assert rst together with call -> pc=0, stack_empty=1.
  - Call at pc=15 then ret -> pc returns to 0.
- PCSEQ_SKIP_EN build:
  - At pc=14: skip=1 -> pc=0.
  - branch=1, cond=1, skip=1, target=6 -> pc=6.
  - branch=1, cond=0, skip=1 at pc=6 -> pc=8.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program-counter sequencer driving the program ROM address.
// Latency: one cycle; the control inputs sampled at a rising edge are reflected on pc after that edge.
// Backpressure: en=0 stalls and freezes all state; optional skip input when PCSEQ_SKIP_EN is defined.
//
// Actions: jump, conditional branch, call/return through a LIFO return stack, and increment.
// When en=1 exactly one action is taken per cycle: call > ret > jump > branch-taken > skip > increment.
//
// Ports:
//   clk, rst (synchronous, active high), en, jump, branch, cond, call, ret, target[ADDR_W]
//   skip (only with PCSEQ_SKIP_EN)
//   pc[ADDR_W], stack_empty, stack_full, stack_err (sticky until rst)
//
// The stack pointer counts occupied entries (0..STACK_DEPTH).
// Over/underflow turn the call/ret into a plain increment and set stack_err.
module pc_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PCSEQ_SKIP_EN
    input  logic              skip,
`endif
    input  logic              en,
    input  logic              jump,
    input  logic              branch,
    input  logic              cond,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // Storage index width; the array is padded to a power of two so any index is in range.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [SLOTS];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_step;
    logic              push_vld;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

`ifdef PCSEQ_SKIP_EN
    // Skip-next-instruction: also applies to a not-taken branch, which falls through here.
    assign pc_step = pc_q + (skip ? ADDR_W'(2) : ADDR_W'(1));
`else
    assign pc_step = pc_inc;
`endif

    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        err_d    = err_q;
        push_vld = 1'b0;
        if (en) begin
            if (call) begin
                // call also wins over a simultaneous ret, which is dropped.
                if (!is_full) begin
                    push_vld = 1'b1;
                    sp_d     = sp_q + SP_W'(1);
                    pc_d     = target;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (ret) begin
                if (!is_empty) begin
                    sp_d = sp_q - SP_W'(1);
                    pc_d = stack_q[pop_idx];
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch && cond) begin
                pc_d = target;
            end else begin
                pc_d = pc_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RST_PC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack contents carry no reset; a push coinciding with rst is discarded.
    always_ff @(posedge clk) begin
        if (!rst && push_vld) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer (ADDR_W=4, STACK_DEPTH=2).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a (bench drives en directly, including stall cycles).
module tb_pc_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int MOD   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          jump = 1'b0;
    logic          branch = 1'b0;
    logic          cond = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          skip = 1'b0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] pc;
    logic          stack_empty;
    logic          stack_full;
    logic          stack_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    pc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef PCSEQ_SKIP_EN
        .skip        (skip),
`endif
        .en          (en),
        .jump        (jump),
        .branch      (branch),
        .cond        (cond),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances the model from the architectural rules, samples after the edge.
    task automatic step(input bit r, input bit e, input bit c, input bit rt, input bit j,
                        input bit b, input bit cd, input bit sk, input int t);
        int inc;
        rst = r; en = e; call = c; ret = rt; jump = j; branch = b; cond = cd; skip = sk;
        target = AW'(t);
        @(posedge clk);
`ifdef PCSEQ_SKIP_EN
        inc = sk ? 2 : 1;
`else
        inc = 1;
`endif
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (e) begin
            if (c) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % MOD);
                    m_pc = t % MOD;
                end else begin
                    m_pc = (m_pc + 1) % MOD;
                    m_err = 1'b1;
                end
            end else if (rt) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = (m_pc + 1) % MOD;
                    m_err = 1'b1;
                end
            end else if (j) m_pc = t % MOD;
            else if (b && cd) m_pc = t % MOD;
            else m_pc = (m_pc + inc) % MOD;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", stack_empty); end
        checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", stack_full); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", stack_err); end
    endtask

    task automatic test_increment;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            idle(1);
            checks++;
            if (pc !== AW'(i % MOD) || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
                errors++;
                $display("FAIL incr[%0d] got pc=%0d empty=%b err=%b want pc=%0d empty=1 err=0",
                         i, pc, stack_empty, stack_err, i % MOD);
            end
        end
    endtask

    task automatic test_jump_branch_stall;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 1, 0, 0, 0, 9);
        checks++; if (pc !== 4'd9) begin errors++; $display("FAIL jump got %0d want 9", pc); end
        step(0, 1, 0, 0, 0, 1, 0, 0, 14);
        checks++; if (pc !== 4'd10) begin errors++; $display("FAIL branch_nt got %0d want 10", pc); end
        step(0, 1, 0, 0, 0, 1, 1, 0, 2);
        checks++; if (pc !== 4'd2) begin errors++; $display("FAIL branch_t got %0d want 2", pc); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, 11);
            checks++; if (pc !== 4'd2) begin errors++; $display("FAIL stall[%0d] got %0d want 2", i, pc); end
        end
    endtask

    task automatic test_call_ret;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        step(0, 1, 1, 0, 0, 0, 0, 0, 12);
        checks++; if (pc !== 4'd12 || stack_empty !== 1'b0) begin errors++; $display("FAIL call1 got pc=%0d empty=%b want 12/0", pc, stack_empty); end
        step(0, 1, 1, 0, 0, 0, 0, 0, 7);
        checks++; if (pc !== 4'd7 || stack_full !== 1'b1) begin errors++; $display("FAIL call2 got pc=%0d full=%b want 7/1", pc, stack_full); end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd13 || stack_full !== 1'b0) begin errors++; $display("FAIL ret1 got pc=%0d full=%b want 13/0", pc, stack_full); end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd6 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++; $display("FAIL ret2 got pc=%0d empty=%b err=%b want 6/1/0", pc, stack_empty, stack_err);
        end
    endtask

    task automatic test_overflow_underflow;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 0, 0, 4);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd5 || stack_err !== 1'b1 || stack_full !== 1'b1) begin
            errors++; $display("FAIL overflow got pc=%0d err=%b full=%b want 5/1/1", pc, stack_err, stack_full);
        end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd2) begin errors++; $display("FAIL ovf_pop1 got %0d want 2", pc); end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd1 || stack_empty !== 1'b1) begin errors++; $display("FAIL ovf_pop2 got pc=%0d empty=%b want 1/1", pc, stack_empty); end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd1 || stack_err !== 1'b1) begin errors++; $display("FAIL underflow got pc=%0d err=%b want 1/1", pc, stack_err); end
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", stack_err); end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", stack_err); end
    endtask

    task automatic test_simultaneous;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 1, 1, 1, 0, 0, 0, 8);
        checks++; if (pc !== 4'd8 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin
            errors++; $display("FAIL call_ret_jump got pc=%0d empty=%b full=%b want 8/0/0", pc, stack_empty, stack_full);
        end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd3) begin errors++; $display("FAIL pushed_addr got %0d want 3", pc); end
        step(0, 1, 1, 0, 0, 0, 0, 0, 9);
        step(1, 1, 1, 0, 0, 0, 0, 0, 9);
        checks++; if (pc !== 4'd0 || stack_empty !== 1'b1) begin errors++; $display("FAIL rst_call got pc=%0d empty=%b want 0/1", pc, stack_empty); end
        step(0, 1, 0, 0, 1, 0, 0, 0, 15);
        step(0, 1, 1, 0, 0, 0, 0, 0, 5);
        checks++; if (pc !== 4'd5) begin errors++; $display("FAIL call_at15 got %0d want 5", pc); end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL ret_wrap got %0d want 0", pc); end
    endtask

`ifdef PCSEQ_SKIP_EN
    task automatic test_skip;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 14);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL skip_wrap got %0d want 0", pc); end
        step(0, 1, 0, 0, 0, 1, 1, 1, 6);
        checks++; if (pc !== 4'd6) begin errors++; $display("FAIL skip_branch_t got %0d want 6", pc); end
        step(0, 1, 0, 0, 0, 1, 0, 1, 3);
        checks++; if (pc !== 4'd8) begin errors++; $display("FAIL skip_branch_nt got %0d want 8", pc); end
    endtask
`endif

    task automatic test_random;
        int bad = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 5) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, MOD - 1)));
            checks++;
            if (pc !== AW'(m_pc) || stack_empty !== (m_stk.size() == 0) ||
                stack_full !== (m_stk.size() == DEPTH) || stack_err !== m_err) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d] got pc=%0d e=%b f=%b err=%b want pc=%0d e=%b f=%b err=%b",
                             i, pc, stack_empty, stack_full, stack_err, m_pc,
                             m_stk.size() == 0, m_stk.size() == DEPTH, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_jump_branch_stall();
        test_call_ret();
        test_overflow_underflow();
        test_simultaneous();
`ifdef PCSEQ_SKIP_EN
        test_skip();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
